vid_timing: RTL and testbench
=============================

VID_TIMING -- requirements
Module: vid_timing

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port enable, input, 1, run request (CR bit 0).
REQ-004 SHALL have ports h1/h2/v1/v2, input, 32 each, timing registers:
- h1 = {htotal[31:16], hactive[15:0]}
- h2 = {hs_end[31:16], hs_start[15:0]}
- v1, v2 use the same layout for vertical.
REQ-005 SHALL have port fifo_data, input, 24, {R,G,B} at pixel FIFO head (first-word-fall-through).
REQ-006 SHALL have port fifo_empty, input, 1, pixel FIFO empty.
REQ-007 SHALL have port fifo_rd, output, 1, pop one pixel this cycle.
REQ-008 SHALL have ports hsync, hblank, vsync, vblank, output, 1 each, registered timing.
REQ-009 SHALL have ports R, G, B, output, 8 each, registered pixel.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse at pixel (0,0).
REQ-011 SHALL have port underflow, output, 1, sticky FIFO-starved flag.

Function
REQ-012 SHALL implement FSM IDLE/RUN:
- IDLE->RUN when enable=1 and shadowed htotal>=2 and vtotal>=2.
- RUN->IDLE when enable=0, effective the next edge.
REQ-013 SHALL copy h1/h2/v1/v2 into shadow registers on IDLE->RUN and at every frame wrap; mid-frame register writes SHALL take effect only at the next frame.
REQ-014 SHALL run 16-bit hcnt 0..htotal-1 in RUN; at wrap hcnt=0 and vcnt increments; vcnt wraps at vtotal-1 (wrap-around at both maxima in the same cycle = frame wrap).
REQ-015 SHALL define active = (hcnt<hactive) && (vcnt<vactive); hactive>htotal SHALL behave as hactive=htotal (same for vertical).
REQ-016 SHALL register outputs with 1-cycle latency from counter state, all mutually aligned:
- hblank = hcnt>=hactive
- hsync = hs_start<=hcnt<hs_end
- vblank = vcnt>=vactive
- vsync = vs_start<=vcnt<vs_end
- hs_end<=hs_start means sync never asserts.
REQ-017 SHALL drive fifo_rd = RUN && active && !fifo_empty (combinational); R/G/B SHALL register fifo_data on that edge.
REQ-018 SHALL, when RUN && active && fifo_empty: drive R=G=B=0, leave fifo_rd=0, set underflow, and still advance the counters.
REQ-019 SHALL drive R=G=B=0 during blanking.
REQ-020 SHALL, in IDLE: hold hcnt=vcnt=0, fifo_rd=0, hblank=vblank=1, hsync=vsync=0, RGB=0.
REQ-021 SHALL pulse frame_start for the cycle in which registered outputs reflect (0,0) in RUN.
REQ-022 SHALL clear underflow only by reset or IDLE entry.

Reset
REQ-023 SHALL, on reset assertion, immediately (asynchronously) force:
- IDLE, counters 0, shadows 0
- hblank=vblank=1, hsync=vsync=0, RGB=0
- frame_start=0, underflow=0
REQ-024 SHALL, on reset mid-frame, abandon the frame and restart from (0,0) after release, provided enable=1 (one cycle to reach RUN).

Structure
REQ-025 SHALL place timing-field struct (total/active/sync_start/sync_end, 16-bit each), state enum, and pixel width constant in shared package vid_pkg.
REQ-026 SHALL use sub-module vid_wrap_cnt (16-bit wrapping counter: en, max, wrap out), instantiated for horizontal and vertical.

Verification
REQ-027 SHALL cover: htotal=10, hactive=6, hs 7..9, vtotal=5, vactive=3, vs 3..4, FIFO never empty -> hblank high 4 of every 10 cycles, hsync high at hcnt 7-8, fifo_rd 18 pulses/frame, frame_start period 50.
REQ-028 SHALL cover: same timing, FIFO empty during hcnt 2 of line 1 -> RGB=0 that pixel, underflow=1 and stays 1, next frame_start still 50 cycles after the previous one.
REQ-029 SHALL cover: h1 rewritten to htotal=12 mid-frame -> current frame keeps period 10 per line, next frame uses 12.
REQ-030 SHALL cover: enable dropped at hcnt=4 -> next cycle fifo_rd=0, blanks=1, underflow cleared; re-enable -> frame_start after the 1-cycle IDLE->RUN transition plus the 1-cycle output latency.
REQ-031 SHALL cover: reset asserted mid-line asynchronously -> outputs reach reset values before next clk edge; htotal=1 config -> stays IDLE.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and helpers for the video timing generator.
// Holds the per-axis timing fields, the FSM states and the pixel width.
package vid_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] sync_start;
    logic [CNT_W-1:0] sync_end;
  } timing_t;

  // Split a {total,active} / {sync_end,sync_start} register pair
  function automatic timing_t f_unpack(
    input logic [31:0] i_r1,
    input logic [31:0] i_r2
  );
    timing_t t;
    t.total      = i_r1[31:16];
    t.active     = i_r1[15:0];
    t.sync_end   = i_r2[31:16];
    t.sync_start = i_r2[15:0];
    return t;
  endfunction

  // Active region, with an oversized active field clamped to total
  function automatic logic f_in_active(
    input logic [CNT_W-1:0] i_cnt,
    input timing_t          i_t
  );
    logic [CNT_W-1:0] lim;
    lim = (i_t.active > i_t.total) ? i_t.total : i_t.active;
    return i_cnt < lim;
  endfunction

  // Sync window [start,end); an empty window never asserts
  function automatic logic f_in_sync(
    input logic [CNT_W-1:0] i_cnt,
    input timing_t          i_t
  );
    return (i_cnt >= i_t.sync_start) && (i_cnt < i_t.sync_end);
  endfunction

endpackage

// File: rtl/vid_wrap_cnt.sv
// 16-bit wrapping counter used for both the pixel and the line count.
// o_wrap flags the advancing cycle in which the count returns to zero.
module vid_wrap_cnt
  import vid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_max,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt >= i_max);
  assign o_cnt  = r_cnt;

  // Count up when enabled, wrap to zero at i_max, clear on request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/vid_timing.sv
// Video timing generator: raster counters, sync/blank and pixel output.
// Timing registers are shadowed at run start and at every frame wrap.
module vid_timing
  import vid_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [31:0]        h1,
  input  logic [31:0]        h2,
  input  logic [31:0]        v1,
  input  logic [31:0]        v2,
  input  logic [3*PIX_W-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  output logic               hsync,
  output logic               hblank,
  output logic               vsync,
  output logic               vblank,
  output logic [PIX_W-1:0]   R,
  output logic [PIX_W-1:0]   G,
  output logic [PIX_W-1:0]   B,
  output logic               frame_start,
  output logic               underflow
);

  state_t  r_state;
  timing_t r_h;
  timing_t r_v;

  logic             r_hsync;
  logic             r_hblank;
  logic             r_vsync;
  logic             r_vblank;
  logic [3*PIX_W-1:0] r_rgb;
  logic             r_frame_start;
  logic             r_underflow;

  timing_t          w_h_in;
  timing_t          w_v_in;
  logic             w_cfg_ok;
  logic             w_run;
  logic             w_active;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_hwrap;
  logic             w_vwrap;

  assign w_h_in   = f_unpack(h1, h2);
  assign w_v_in   = f_unpack(v1, v2);
  assign w_cfg_ok = (w_h_in.total >= 16'd2) && (w_v_in.total >= 16'd2);

  // Dropping enable in RUN takes effect at the very next edge
  assign w_run    = (r_state == ST_RUN) && enable;
  assign w_active = f_in_active(w_hcnt, r_h) && f_in_active(w_vcnt, r_v);
  assign fifo_rd  = (r_state == ST_RUN) && w_active && !fifo_empty;

  vid_wrap_cnt u_hcnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_run),
    .i_en   (w_run),
    .i_max  (r_h.total - 16'd1),
    .o_cnt  (w_hcnt),
    .o_wrap (w_hwrap)
  );

  vid_wrap_cnt u_vcnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_run),
    .i_en   (w_run && w_hwrap),
    .i_max  (r_v.total - 16'd1),
    .o_cnt  (w_vcnt),
    .o_wrap (w_vwrap)
  );

  // Run/idle control and shadow reload at start and frame wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (enable && w_cfg_ok) begin
            r_state <= ST_RUN;
            r_h     <= w_h_in;
            r_v     <= w_v_in;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_vwrap) begin
            if (w_cfg_ok) begin
              r_h <= w_h_in;
              r_v <= w_v_in;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Registered timing and pixel outputs, one cycle behind the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= 1'b0;
      r_hblank      <= 1'b1;
      r_vsync       <= 1'b0;
      r_vblank      <= 1'b1;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (!w_run) begin
      r_hsync       <= 1'b0;
      r_hblank      <= 1'b1;
      r_vsync       <= 1'b0;
      r_vblank      <= 1'b1;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_hsync       <= f_in_sync(w_hcnt, r_h);
      r_hblank      <= !f_in_active(w_hcnt, r_h);
      r_vsync       <= f_in_sync(w_vcnt, r_v);
      r_vblank      <= !f_in_active(w_vcnt, r_v);
      r_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
      r_rgb         <= (w_active && !fifo_empty) ? fifo_data : '0;
      if (w_active && fifo_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign hsync       = r_hsync;
  assign hblank      = r_hblank;
  assign vsync       = r_vsync;
  assign vblank      = r_vblank;
  assign R           = r_rgb[3*PIX_W-1:2*PIX_W];
  assign G           = r_rgb[2*PIX_W-1:PIX_W];
  assign B           = r_rgb[PIX_W-1:0];
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_vid_timing.sv
// Directed bench for vid_timing: 10x5 raster, starvation, mid-frame
// register rewrite, enable drop, async reset and an invalid total.
module tb_vid_timing;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] h1, h2, v1, v2;
  logic [23:0] fifo_data;
  logic        fifo_empty = 1'b0;
  logic        fifo_rd;
  logic        hsync, hblank, vsync, vblank;
  logic [7:0]  R, G, B;
  logic        frame_start, underflow;

  int checks = 0;
  int failures = 0;
  int fifo_n = 0;
  int exp_n = 0;
  logic exp_uf = 1'b0;
  int rd_cnt, hb_cnt, fs_cnt;

  vid_timing dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .h1          (h1),
    .h2          (h2),
    .v1          (v1),
    .v2          (v2),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .hsync       (hsync),
    .hblank      (hblank),
    .vsync       (vsync),
    .vblank      (vblank),
    .R           (R),
    .G           (G),
    .B           (B),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {b, ~b, b ^ 8'h5A};
  endfunction

  // Pixel FIFO model: head word advances on every pop
  assign fifo_data = pix(fifo_n);
  always @(posedge clk) if (fifo_rd) fifo_n <= fifo_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  // Check ncyc output samples; sample k reflects raster position k
  task automatic run_frame(input int htot, input int starve,
                           input int wr_k, input int ncyc,
                           output int rd, output int hb);
    int h, v;
    logic act;
    logic [4:0] ev;
    logic [23:0] er;
    rd = 0;
    hb = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      h = k % htot;
      v = k / htot;
      act = (h < 6) && (v < 3);
      if (k == starve) begin
        er = '0;
        exp_uf = 1'b1;
      end else if (act) begin
        er = pix(exp_n);
        exp_n++;
      end else begin
        er = '0;
      end
      ev = {k == 0, h >= 6, (h >= 7) && (h < 9), v >= 3, v == 3};
      chk("timing", {frame_start, hblank, hsync, vblank, vsync}, ev);
      chk("rgb", {R, G, B}, er);
      chk("underflow", underflow, exp_uf);
      if (fifo_rd) rd++;
      if (k < htot && hblank) hb++;
      if (k == wr_k) h1 = {16'd12, 16'd6};
      fifo_empty = (k + 1 == starve);
    end
  endtask

  initial begin
    h1 = {16'd10, 16'd6};
    h2 = {16'd9, 16'd7};
    v1 = {16'd5, 16'd3};
    v2 = {16'd4, 16'd3};
    #1 reset = 1'b1;
    #2;
    chk("rst_timing", {frame_start, hblank, hsync, vblank, vsync}, 5'b01010);
    chk("rst_rgb", {R, G, B}, 24'h0);
    chk("rst_uf", underflow, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("start_fs", frame_start, 1'b0);
    chk("start_hb", hblank, 1'b1);

    // Nominal frame, FIFO always full
    run_frame(10, -1, -1, 50, rd_cnt, hb_cnt);
    chk("rd_frame1", rd_cnt, 18);
    chk("hb_line1", hb_cnt, 4);

    // Starved pixel at hcnt 2 of line 1
    run_frame(10, 12, -1, 50, rd_cnt, hb_cnt);
    chk("rd_starve", rd_cnt, 17);

    // htotal rewritten mid-frame; only the next frame uses 12
    run_frame(10, -1, 20, 50, rd_cnt, hb_cnt);
    chk("rd_frame3", rd_cnt, 18);
    chk("hb_old", hb_cnt, 4);
    run_frame(12, -1, -1, 60, rd_cnt, hb_cnt);
    chk("rd_frame4", rd_cnt, 18);
    chk("hb_new", hb_cnt, 6);

    // Drop enable with hcnt=4 live, then re-enable
    run_frame(12, -1, -1, 4, rd_cnt, hb_cnt);
    h1 = {16'd10, 16'd6};
    enable = 1'b0;
    chk("rd_at_drop", fifo_rd, 1'b1);
    exp_n++;
    @(negedge clk);
    chk("drop_rd", fifo_rd, 1'b0);
    chk("drop_blank", {hblank, vblank}, 2'b11);
    chk("drop_uf", underflow, 1'b0);
    chk("drop_rgb", {R, G, B}, 24'h0);
    exp_uf = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("reen_fs", frame_start, 1'b0);
    run_frame(10, -1, -1, 50, rd_cnt, hb_cnt);
    chk("rd_reen", rd_cnt, 18);

    // Async reset mid-line after a starved pixel
    run_frame(10, 1, -1, 3, rd_cnt, hb_cnt);
    #2 reset = 1'b1;
    #1;
    chk("arst_timing", {frame_start, hblank, hsync, vblank, vsync}, 5'b01010);
    chk("arst_rgb", {R, G, B}, 24'h0);
    chk("arst_uf", underflow, 1'b0);
    chk("arst_rd", fifo_rd, 1'b0);
    exp_uf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_fs", frame_start, 1'b0);
    run_frame(10, -1, -1, 50, rd_cnt, hb_cnt);
    chk("rd_after_rst", rd_cnt, 18);

    // htotal=1 must never leave IDLE
    reset = 1'b1;
    h1 = {16'd1, 16'd6};
    @(negedge clk);
    reset = 1'b0;
    fs_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (fifo_rd) rd_cnt++;
    end
    chk("ht1_fs", fs_cnt, 0);
    chk("ht1_rd", rd_cnt, 0);
    chk("ht1_hb", hblank, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
